// File: rtl/phy_mdio_init.sv
// PHY bring-up sequencer: soft-resets the PHY over an MDIO request/ack engine,
// programs autoneg advertisement, restarts autoneg, then polls BMSR forever.
module phy_mdio_init #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned POR_WAIT     = 10000,
  parameter int unsigned POLL_GAP     = 1000,
  parameter int unsigned RST_POLL_MAX = 16
) (
  input  logic        clk,
  input  logic        rest_n,
  output logic        ren,
  output logic        wen,
  output logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic [15:0] wdata,
  input  logic [15:0] rdata,
  input  logic        rw_ready,
  output logic        init_done,
  output logic        link_up,
  output logic        an_done,
  output logic        init_err
);

  localparam int unsigned CNT_MAX = (POR_WAIT > POLL_GAP) ? POR_WAIT : POLL_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 2);
  localparam int unsigned PW      = $clog2(RST_POLL_MAX + 2);

  localparam logic [CW-1:0] POR_TERM  = CW'(POR_WAIT);
  localparam logic [CW-1:0] GAP_TERM  = CW'(POLL_GAP);
  localparam logic [PW-1:0] POLL_TERM = PW'(RST_POLL_MAX);

  typedef enum logic [2:0] {
    POR_DLY, W_RST, P_RST, W_ANAR, W_BMCR, GAP, R_BMSR, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0] poll_q, poll_d, poll_inc;
  logic          gap_wait_q, gap_wait_d;
  logic          ren_q, ren_d, wen_q, wen_d;
  logic [4:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          done_q, done_d, link_q, link_d, an_q, an_d, err_q, err_d;
  logic          xfer;
  logic          unused_rdata;

  assign cnt_inc      = cnt_q + CW'(1);
  assign poll_inc     = poll_q + PW'(1);
  assign xfer         = (ren_q | wen_q) & rw_ready;
  assign unused_rdata = ^{rdata[14:6], rdata[4:3], rdata[1:0]};

  // Every request state issues on the first cycle its request line is low;
  // that cycle doubles as the mandatory idle cycle after the previous ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    gap_wait_d = gap_wait_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    link_d     = link_q;
    an_d       = an_q;
    err_d      = err_q;

    case (state_q)
      POR_DLY: begin
        if (cnt_inc >= POR_TERM) begin
          state_d = W_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      W_RST: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          addr_d  = 5'd0;
          wdata_d = 16'h8000;
        end else if (xfer) begin
          wen_d      = 1'b0;
          poll_d     = '0;
          gap_wait_d = 1'b0;
          cnt_d      = '0;
          state_d    = P_RST;
        end
      end

      P_RST: begin
        if (gap_wait_q) begin
          if (cnt_inc >= GAP_TERM) begin
            gap_wait_d = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!ren_q) begin
          ren_d   = 1'b1;
          addr_d  = 5'd0;
          wdata_d = '0;
        end else if (xfer) begin
          ren_d  = 1'b0;
          poll_d = poll_inc;
          cnt_d  = '0;
          if (!rdata[15]) begin
            state_d = W_ANAR;
          end else if (poll_inc >= POLL_TERM) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            gap_wait_d = 1'b1;
          end
        end
      end

      W_ANAR: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          addr_d  = 5'd4;
          wdata_d = 16'h01E1;
        end else if (xfer) begin
          wen_d   = 1'b0;
          state_d = W_BMCR;
        end
      end

      W_BMCR: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          addr_d  = 5'd0;
          wdata_d = 16'h1200;
        end else if (xfer) begin
          wen_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (cnt_inc >= GAP_TERM) begin
          state_d = R_BMSR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      R_BMSR: begin
        if (!ren_q) begin
          ren_d   = 1'b1;
          addr_d  = 5'd1;
          wdata_d = '0;
        end else if (xfer) begin
          ren_d   = 1'b0;
          link_d  = rdata[2];
          an_d    = rdata[5];
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      ERR: begin
        if (cnt_inc >= GAP_TERM) begin
          state_d = W_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = POR_DLY;
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q    <= POR_DLY;
      cnt_q      <= '0;
      poll_q     <= '0;
      gap_wait_q <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      link_q     <= 1'b0;
      an_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      gap_wait_q <= gap_wait_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      link_q     <= link_d;
      an_q       <= an_d;
      err_q      <= err_d;
    end
  end

  assign phy_addr  = PHY_ADDR;
  assign ren       = ren_q;
  assign wen       = wen_q;
  assign reg_addr  = addr_q;
  assign wdata     = wdata_q;
  assign init_done = done_q;
  assign link_up   = link_q;
  assign an_done   = an_q;
  assign init_err  = err_q;

endmodule
